// File: rtl/bcd_count_ctrl_if.sv
// rtl/bcd_count_ctrl_if.sv - command/status bundle between a front panel and the BCD count controller
interface bcd_count_ctrl_if #(
    parameter int DIGITS = 4
);
    // Commands from the panel side
    logic                  start;
    logic                  stop;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  up_down;

    // Status back to the display side
    logic [4*DIGITS-1:0]   count;
    logic                  running;
    logic                  tc;
    logic                  done;

    modport master (
        output start, stop, clear, load, load_value, up_down,
        input  count, running, tc, done
    );

    modport slave (
        input  start, stop, clear, load, load_value, up_down,
        output count, running, tc, done
    );
endinterface

// File: rtl/bcd_count_ctrl.sv
// rtl/bcd_count_ctrl.sv - run/pause/clear controller and single-cycle ripple sequencer for a BCD counter chain
module bcd_count_ctrl #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 1,
    parameter int WRAP     = 1
) (
    input  logic               clk,
    input  logic               reset,
    bcd_count_ctrl_if.slave    bus
);
    localparam int          W        = 4 * DIGITS;
    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] count_q, count_d;
    logic [15:0]  pre_q,   pre_d;
    logic         tc_q,    tc_d;

    logic [W-1:0] load_clamped;
    logic [W-1:0] stepped;
    logic [W-1:0] nines;
    logic         at_term;
    logic         lands_term;
    logic         step_due;

    // Parallel load value with any out-of-range nibble forced to 9 so count stays BCD
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.load_value[4*i +: 4] > 4'd9) begin
                load_clamped[4*i +: 4] = 4'd9;
            end else begin
                load_clamped[4*i +: 4] = bus.load_value[4*i +: 4];
            end
        end
    end

    // One-step ripple across all digits; at_term means the carry/borrow ran off the top
    always_comb begin : p_ripple
        logic carry;
        carry   = 1'b1;
        stepped = count_q;
        nines   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            nines[4*i +: 4] = 4'd9;
            if (carry) begin
                if (bus.up_down) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
        at_term    = carry;
        lands_term = bus.up_down ? (stepped == nines) : (stepped == '0);
    end

    assign step_due = (state_q == ST_RUN) && (pre_q == PRE_LAST);

    // Command decode (clear > load > stop > start) and run-time stepping
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pre_d   = pre_q;
        tc_d    = 1'b0;
        if (bus.clear) begin
            state_d = ST_IDLE;
            count_d = '0;
            pre_d   = '0;
        end else if (bus.load) begin
            state_d = ST_IDLE;
            count_d = load_clamped;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_d = ST_RUN;
                        pre_d   = '0;
                    end
                end
                ST_PAUSE: begin
                    // prescaler is left as it was so the resumed step keeps its phase
                    if (bus.start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_due) begin
                        pre_d = '0;
                        if (WRAP != 0) begin
                            count_d = stepped;
                            tc_d    = at_term;
                        end else if (at_term) begin
                            // started while already sitting on the terminal value
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d = stepped;
                            if (lands_term) begin
                                tc_d    = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                    // the RUN cycle still advances the prescaler; reaching DONE wins over a pause
                    if (bus.stop && (state_d == ST_RUN)) begin
                        state_d = ST_PAUSE;
                    end
                end
                default: begin
                    // DONE: held until clear or load
                end
            endcase
        end
    end

    // State, count, prescaler and terminal pulse registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pre_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pre_q   <= pre_d;
            tc_q    <= tc_d;
        end
    end

    assign bus.count   = count_q;
    assign bus.running = (state_q == ST_RUN);
    assign bus.done    = (state_q == ST_DONE);
    assign bus.tc      = tc_q;

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb/tb_bcd_count_ctrl.sv - scoreboard bench for bcd_count_ctrl across wrap, saturate and prescaled variants
module tb_bcd_count_ctrl;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    event chk_ev;

    localparam int F_COUNT   = 0;
    localparam int F_RUNNING = 1;
    localparam int F_TC      = 2;
    localparam int F_DONE    = 3;

    typedef struct {
        int          cyc;
        int          dut;
        int          fld;
        logic [31:0] val;
        string       nm;
    } exp_t;

    exp_t sb[$];

    bcd_count_ctrl_if #(.DIGITS(4)) if0 ();
    bcd_count_ctrl_if #(.DIGITS(4)) if1 ();
    bcd_count_ctrl_if #(.DIGITS(4)) if2 ();

    bcd_count_ctrl #(.DIGITS(4), .TICK_DIV(1), .WRAP(1)) u_wrap (.clk(clk), .reset(reset), .bus(if0));
    bcd_count_ctrl #(.DIGITS(4), .TICK_DIV(1), .WRAP(0)) u_sat  (.clk(clk), .reset(reset), .bus(if1));
    bcd_count_ctrl #(.DIGITS(4), .TICK_DIV(3), .WRAP(1)) u_pre  (.clk(clk), .reset(reset), .bus(if2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(int n);
        logic [15:0] r;
        int          v;
        r = '0;
        v = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] get_val(int d, int f);
        logic [15:0] c;
        logic        r, t, dn;
        case (d)
            0:       begin c = if0.count; r = if0.running; t = if0.tc; dn = if0.done; end
            1:       begin c = if1.count; r = if1.running; t = if1.tc; dn = if1.done; end
            default: begin c = if2.count; r = if2.running; t = if2.tc; dn = if2.done; end
        endcase
        case (f)
            F_COUNT:   return {16'd0, c};
            F_RUNNING: return {31'd0, r};
            F_TC:      return {31'd0, t};
            default:   return {31'd0, dn};
        endcase
    endfunction

    task automatic push_exp(int dly, int dut, int fld, logic [31:0] v, string nm);
        exp_t e;
        e.cyc = cyc + dly;
        e.dut = dut;
        e.fld = fld;
        e.val = v;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: compares every queued expectation whose cycle has arrived
    int          mi;
    logic [31:0] act;
    initial begin
        forever begin
            @(negedge clk or chk_ev);
            mi = 0;
            while (mi < sb.size()) begin
                if (sb[mi].cyc <= cyc) begin
                    act    = get_val(sb[mi].dut, sb[mi].fld);
                    checks = checks + 1;
                    if (act !== sb[mi].val) begin
                        errors = errors + 1;
                        $display("FAIL %s: dut%0d cycle %0d got %0h expected %0h",
                                 sb[mi].nm, sb[mi].dut, cyc, act, sb[mi].val);
                    end
                    sb.delete(mi);
                end else begin
                    mi = mi + 1;
                end
            end
        end
    end

    task automatic idle_cmds();
        if0.start = 0; if0.stop = 0; if0.clear = 0; if0.load = 0; if0.load_value = '0; if0.up_down = 1;
        if1.start = 0; if1.stop = 0; if1.clear = 0; if1.load = 0; if1.load_value = '0; if1.up_down = 1;
        if2.start = 0; if2.stop = 0; if2.clear = 0; if2.load = 0; if2.load_value = '0; if2.up_down = 1;
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idle_cmds();

        // Reset state on all three variants
        step();
        for (int d = 0; d < 3; d++) begin
            push_exp(0, d, F_COUNT,   0, "reset_count");
            push_exp(0, d, F_RUNNING, 0, "reset_running");
            push_exp(0, d, F_TC,      0, "reset_tc");
            push_exp(0, d, F_DONE,    0, "reset_done");
        end
        step();
        step();
        reset = 1'b1;
        step();

        // Up count 0000..0010 on consecutive edges
        if0.start = 1;
        push_exp(1, 0, F_RUNNING, 1, "up_running");
        push_exp(1, 0, F_COUNT,   0, "up_start_count");
        step();
        if0.start = 0;
        push_exp(1, 0, F_TC, 0, "up_tc_low");
        for (int k = 1; k <= 10; k++) push_exp(k, 0, F_COUNT, to_bcd(k), "up_count");
        repeat (10) step();

        // Wrap 9998 -> 9999 -> 0000 with tc only on the 0000 cycle
        if0.load = 1;
        if0.load_value = 16'h9998;
        push_exp(1, 0, F_COUNT,   32'h9998, "wrap_load");
        push_exp(1, 0, F_RUNNING, 0,        "wrap_load_idle");
        step();
        if0.load = 0;
        if0.start = 1;
        push_exp(1, 0, F_RUNNING, 1, "wrap_running");
        step();
        if0.start = 0;
        push_exp(1, 0, F_COUNT,   32'h9999, "wrap_9999");
        push_exp(1, 0, F_TC,      0,        "wrap_tc_before");
        push_exp(2, 0, F_COUNT,   32'h0000, "wrap_0000");
        push_exp(2, 0, F_TC,      1,        "wrap_tc");
        push_exp(2, 0, F_RUNNING, 1,        "wrap_still_running");
        push_exp(3, 0, F_COUNT,   32'h0001, "wrap_0001");
        push_exp(3, 0, F_TC,      0,        "wrap_tc_after");
        repeat (3) step();

        // Command priority: clear beats everything, then load with clamping
        if0.clear = 1; if0.load = 1; if0.stop = 1; if0.start = 1;
        if0.load_value = 16'h1234;
        push_exp(1, 0, F_COUNT,   0, "prio_clear_count");
        push_exp(1, 0, F_RUNNING, 0, "prio_clear_idle");
        step();
        if0.clear = 0; if0.stop = 0; if0.start = 0;
        if0.load_value = 16'hF3A1;
        push_exp(1, 0, F_COUNT,   32'h9391, "load_clamp");
        push_exp(1, 0, F_RUNNING, 0,        "load_idle");
        step();
        if0.load = 0;

        // Down count with borrow, saturating at 0000 (WRAP=0)
        if1.up_down = 0;
        if1.load = 1;
        if1.load_value = 16'h0101;
        push_exp(1, 1, F_COUNT, 32'h0101, "down_load");
        step();
        if1.load = 0;
        if1.start = 1;
        push_exp(1, 1, F_RUNNING, 1, "down_running");
        step();
        if1.start = 0;
        push_exp(1,   1, F_COUNT,   32'h0100, "down_0100");
        push_exp(2,   1, F_COUNT,   32'h0099, "down_borrow_0099");
        push_exp(3,   1, F_COUNT,   32'h0098, "down_0098");
        push_exp(100, 1, F_COUNT,   32'h0001, "down_0001");
        push_exp(100, 1, F_TC,      0,        "down_tc_before");
        push_exp(101, 1, F_COUNT,   32'h0000, "down_0000");
        push_exp(101, 1, F_TC,      1,        "down_tc");
        push_exp(101, 1, F_DONE,    1,        "down_done");
        push_exp(101, 1, F_RUNNING, 0,        "down_not_running");
        push_exp(102, 1, F_TC,      0,        "down_tc_pulse_end");
        push_exp(102, 1, F_DONE,    1,        "down_done_hold");
        repeat (102) step();
        if1.start = 1;
        push_exp(1, 1, F_COUNT,   0, "done_start_count");
        push_exp(1, 1, F_DONE,    1, "done_start_ignored");
        push_exp(1, 1, F_RUNNING, 0, "done_start_not_run");
        step();
        if1.start = 0;
        step();

        // Prescaler TICK_DIV=3 with pause/resume
        if2.start = 1;
        push_exp(1, 2, F_RUNNING, 1, "pre_running");
        push_exp(1, 2, F_COUNT,   0, "pre_count_c1");
        push_exp(3, 2, F_COUNT,   0, "pre_count_c3");
        push_exp(4, 2, F_COUNT,   1, "pre_first_step");
        step();
        if2.start = 0;
        repeat (3) step();
        if2.stop = 1;
        step();
        if2.stop = 0;
        push_exp(0, 2, F_RUNNING, 0, "pause_not_running");
        push_exp(0, 2, F_COUNT,   1, "pause_count_start");
        push_exp(9, 2, F_COUNT,   1, "pause_count_end");
        push_exp(9, 2, F_TC,      0, "pause_tc");
        repeat (10) step();
        if2.start = 1;
        push_exp(1, 2, F_RUNNING, 1, "resume_running");
        push_exp(2, 2, F_COUNT,   1, "resume_hold");
        push_exp(3, 2, F_COUNT,   2, "resume_step");
        step();
        if2.start = 0;
        repeat (3) step();

        // Asynchronous reset in the middle of a run at 0457
        if0.load = 1;
        if0.load_value = 16'h0450;
        push_exp(1, 0, F_COUNT, 32'h0450, "areset_load");
        step();
        if0.load = 0;
        if0.start = 1;
        step();
        if0.start = 0;
        repeat (7) step();
        push_exp(0, 0, F_COUNT,   32'h0457, "areset_pre_count");
        push_exp(0, 0, F_RUNNING, 1,        "areset_pre_running");
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        push_exp(0, 0, F_COUNT,   0, "areset_count");
        push_exp(0, 0, F_RUNNING, 0, "areset_running");
        push_exp(0, 0, F_TC,      0, "areset_tc");
        push_exp(0, 2, F_RUNNING, 0, "areset_other_idle");
        -> chk_ev;
        #1;
        step();
        push_exp(0, 0, F_COUNT, 0, "areset_held");
        reset = 1'b1;
        step();
        step();

        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
